hr_inject_ctrl: RTL and testbench
=================================

Name: hr_inject_ctrl

Overview:
- Local-injection scheduler placed in front of one HRnode.
- Shares the node's two local injection ports (port0_local_i, port1_local_i) among NREQ local requesters (cores, cache slices, NI).
- Holds each offered flit stable until the node's portl0_ack/portl1_ack accepts it.
- Arbitrates round-robin per lane; flags starvation and protocol errors; counts injected flits.

Parameters:
- NREQ, 4, number of local requesters.
- FLIT_W, 144, flit width; equals `control_w.
- STARVE_MAX, 255, consecutive un-acked offer cycles before starve flag sets.
- CNT_W, 16, width of per-lane injected-flit counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_en_i  in  1  grant enable; 0 = no new grants, held flits still drain.
- req_valid_i  in  NREQ  requester i has a flit.
- req_lane_i  in  NREQ  target lane per requester; 0 = port0_local, 1 = port1_local.
- req_flit_i  in  NREQ*FLIT_W  flit of requester i at bits [i*FLIT_W +: FLIT_W].
- req_ready_o  out  NREQ  one-hot per lane; flit i taken at this edge when valid&ready.
- portl0_ack_i  in  1  from HRnode portl0_ack.
- portl1_ack_i  in  1  from HRnode portl1_ack.
- port0_local_o  out  FLIT_W  to HRnode port0_local_i.
- port1_local_o  out  FLIT_W  to HRnode port1_local_i.
- starve_o  out  2  per-lane starvation flag.
- ack_err_o  out  1  sticky: ack seen on an empty lane.
- inj_cnt0_o  out  CNT_W  flits accepted on lane 0.
- inj_cnt1_o  out  CNT_W  flits accepted on lane 1.

Behaviour:
- Empty-slot encoding: an empty injection slot is driven as all-zero FLIT_W. A requester never presents an all-zero flit as valid.
- Reset (rst=0, async) sets:
  - both holding registers empty; port*_local_o = 0;
  - RR pointers = 0;
  - starve counters = 0, starve_o = 0, ack_err_o = 0;
  - inj_cnt* = 0;
  - req_ready_o = 0 while rst=0.
- Reset mid-operation: a held flit is discarded and is not counted.
- Per-lane FSM, 2 states:
  - EMPTY: output 0. A grant moves it to FULL.
  - FULL: output = held flit, stable until acked.
  - In FULL, ack and no new grant -> EMPTY.
  - In FULL, ack and new grant -> stays FULL with the new flit (back-to-back, 1 flit/cycle/lane).
- Grant condition for lane L:
  - cfg_en_i=1, and
  - (lane EMPTY, or lane FULL with ack_L=1 this cycle), and
  - at least one i has req_valid_i[i]=1 and req_lane_i[i]=L.
- Grant selection: round-robin winner. Search starts at rr_ptr_L, wrapping NREQ-1 -> 0.
- req_ready_o[winner]=1, combinational from the current-cycle inputs. At the edge the flit is captured and rr_ptr_L <= winner+1 (mod NREQ).
- The two lanes arbitrate independently. Any requester is granted at most one lane per cycle, since req_lane_i is a single bit.
- Latency: flit appears on port*_local_o the cycle after its valid&ready edge.
- Ack semantics: ack_L high in a cycle means HRnode accepted the flit presented that cycle.
- ack_L while lane L is EMPTY: ignored, and ack_err_o sets (sticky until reset).
- inj_cntL: increments on each ack in FULL; wraps 2^CNT_W-1 -> 0.
- Starvation, per lane:
  - counter increments each cycle the lane is FULL with no ack;
  - saturates at STARVE_MAX; starve_o[L]=1 while counter == STARVE_MAX;
  - counter clears on ack or EMPTY.
- cfg_en_i falling: no grants from the next evaluation. Held flits stay offered until acked.
- No combinational path from portl*_ack_i to port*_local_o. The ack -> req_ready_o path is combinational, by design.

Decomposition:
- Shared package / defines.v holds:
  - FLIT_W (via `control_w);
  - the empty-flit constant (all zero);
  - lane encodings LANE0=0, LANE1=1.
- One natural sub-module, hr_rr_arb: NREQ-wide round-robin arbiter with request vector, pointer, one-hot grant and advance.
  - Instantiated once per lane.
  - Lane FSM, starvation counter and injection counter live in hr_inject_ctrl.

Test Plan:
- Reset: rst=0 with req_valid=4'b1111 -> all outputs 0, req_ready=0. After rst=1, first grant goes to requester 0.
- Single inject: req0 valid, lane 0, flit 144'h...1855, ack held 0.
  - Cycle+1: port0_local_o = 144'h...1855, stable 10 cycles.
  - Ack on cycle 11 -> output 0 next cycle, inj_cnt0_o = 1.
- Round-robin: all 4 requesters valid on lane 0, ack=1 every cycle -> grants 0,1,2,3,0 on consecutive cycles; one flit per cycle on port0_local_o.
- Dual lane: req0->lane0 and req1->lane1 simultaneously -> both granted the same cycle; both ports show their flits the next cycle.
- Starvation: one flit held on lane 1, portl1_ack=0 -> starve_o[1]=1 after 255 cycles; clears the cycle after ack.
- Errors and edges:
  - portl0_ack_i=1 while lane 0 EMPTY -> ack_err_o=1 and stays 1.
  - 65536 acked flits -> inj_cnt0_o wraps to 0.
  - cfg_en_i=0 while FULL -> flit drains, no new grant.

Source files
------------

// File: rtl/hr_inject_ctrl_pkg.sv
// Shared types and constants for the HRnode local-injection scheduler.
// Flit width tracks the node control word width.
package hr_inject_ctrl_pkg;

    localparam int CONTROL_W = 144;

    localparam logic [CONTROL_W-1:0] EMPTY_FLIT = '0;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_st_t;

endpackage

// File: rtl/hr_inject_ctrl_if.sv
// Requester / HRnode-facing bundle of the injection scheduler.
// slave is the scheduler side, master is the environment side.
interface hr_inject_ctrl_if #(
    parameter int NREQ   = 4,
    parameter int FLIT_W = 144,
    parameter int CNT_W  = 16
);

    logic                   cfg_en_i;
    logic [NREQ-1:0]        req_valid_i;
    logic [NREQ-1:0]        req_lane_i;
    logic [NREQ*FLIT_W-1:0] req_flit_i;
    logic [NREQ-1:0]        req_ready_o;
    logic                   portl0_ack_i;
    logic                   portl1_ack_i;
    logic [FLIT_W-1:0]      port0_local_o;
    logic [FLIT_W-1:0]      port1_local_o;
    logic [1:0]             starve_o;
    logic                   ack_err_o;
    logic [CNT_W-1:0]       inj_cnt0_o;
    logic [CNT_W-1:0]       inj_cnt1_o;

    modport slave (
        input  cfg_en_i,
        input  req_valid_i,
        input  req_lane_i,
        input  req_flit_i,
        input  portl0_ack_i,
        input  portl1_ack_i,
        output req_ready_o,
        output port0_local_o,
        output port1_local_o,
        output starve_o,
        output ack_err_o,
        output inj_cnt0_o,
        output inj_cnt1_o
    );

    modport master (
        output cfg_en_i,
        output req_valid_i,
        output req_lane_i,
        output req_flit_i,
        output portl0_ack_i,
        output portl1_ack_i,
        input  req_ready_o,
        input  port0_local_o,
        input  port1_local_o,
        input  starve_o,
        input  ack_err_o,
        input  inj_cnt0_o,
        input  inj_cnt1_o
    );

endinterface

// File: rtl/hr_rr_arb.sv
// Round-robin arbiter: search starts at ptr, wraps NREQ-1 -> 0.
// On advance the pointer moves just past the current winner.
module hr_rr_arb #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             advance,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] ptr_q;

    always_comb begin : search
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(ptr_q) + k) % NREQ;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IDX_W'(j);
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (advance && any) begin
            ptr_q <= (idx == IDX_W'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/hr_inject_ctrl.sv
// Shares the two HRnode local injection ports among NREQ requesters,
// holding each flit until acked; flags starvation and stray acks.
module hr_inject_ctrl
    import hr_inject_ctrl_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int FLIT_W     = CONTROL_W,
    parameter int STARVE_MAX = 255,
    parameter int CNT_W      = 16
) (
    input logic             clk,
    input logic             rst,
    hr_inject_ctrl_if.slave bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW    = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]     SMAX = SW'(STARVE_MAX);
    localparam logic [FLIT_W-1:0] NONE = FLIT_W'(EMPTY_FLIT);

    logic [1:0]        ack;
    logic [NREQ-1:0]   req0;
    logic [NREQ-1:0]   req1;
    logic [NREQ-1:0]   gnt0;
    logic [NREQ-1:0]   gnt1;
    logic [IDX_W-1:0]  idx0;
    logic [IDX_W-1:0]  idx1;
    logic              any0;
    logic              any1;
    logic [1:0]        any;
    logic [1:0]        take;
    logic [1:0]        full;
    logic [FLIT_W-1:0] sel [2];

    lane_st_t          st_q   [2];
    lane_st_t          st_d   [2];
    logic [FLIT_W-1:0] flit_q [2];
    logic [FLIT_W-1:0] flit_d [2];
    logic [SW-1:0]     stv_q  [2];
    logic [CNT_W-1:0]  cnt_q  [2];
    logic              err_q;
    logic [NREQ-1:0]   rdy;

    assign ack  = {bus.portl1_ack_i, bus.portl0_ack_i};
    assign any  = {any1, any0};
    assign full = {st_q[1] == FULL, st_q[0] == FULL};

    assign sel[0] = bus.req_flit_i[int'(idx0)*FLIT_W +: FLIT_W];
    assign sel[1] = bus.req_flit_i[int'(idx1)*FLIT_W +: FLIT_W];

    always_comb begin
        req0 = '0;
        req1 = '0;
        for (int i = 0; i < NREQ; i++) begin
            req0[i] = bus.req_valid_i[i] & (bus.req_lane_i[i] == LANE0);
            req1[i] = bus.req_valid_i[i] & (bus.req_lane_i[i] == LANE1);
        end
    end

    hr_rr_arb #(.NREQ(NREQ)) u_arb0 (
        .clk     (clk),
        .rst     (rst),
        .req     (req0),
        .advance (take[0]),
        .gnt     (gnt0),
        .idx     (idx0),
        .any     (any0)
    );

    hr_rr_arb #(.NREQ(NREQ)) u_arb1 (
        .clk     (clk),
        .rst     (rst),
        .req     (req1),
        .advance (take[1]),
        .gnt     (gnt1),
        .idx     (idx1),
        .any     (any1)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int l = 0; l < 2; l++) begin
                st_q[l]   <= EMPTY;
                flit_q[l] <= NONE;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                st_q[l]   <= st_d[l];
                flit_q[l] <= flit_d[l];
            end
        end
    end

    // A full lane may take a new flit in the same cycle its current one is acked.
    always_comb begin
        take = '0;
        for (int l = 0; l < 2; l++) begin
            take[l]   = bus.cfg_en_i & any[l] & (~full[l] | ack[l]);
            st_d[l]   = st_q[l];
            flit_d[l] = flit_q[l];
            unique case (st_q[l])
                EMPTY:   if (take[l]) st_d[l] = FULL;
                FULL:    if (ack[l] && !take[l]) st_d[l] = EMPTY;
                default: st_d[l] = EMPTY;
            endcase
            if (take[l]) begin
                flit_d[l] = sel[l];
            end else if (st_d[l] == EMPTY) begin
                flit_d[l] = NONE;
            end
        end
    end

    always_comb begin
        rdy = '0;
        if (rst) begin
            if (take[0]) rdy = rdy | gnt0;
            if (take[1]) rdy = rdy | gnt1;
        end
        bus.req_ready_o   = rdy;
        bus.port0_local_o = full[0] ? flit_q[0] : NONE;
        bus.port1_local_o = full[1] ? flit_q[1] : NONE;
        bus.starve_o      = {stv_q[1] == SMAX, stv_q[0] == SMAX};
        bus.ack_err_o     = err_q;
        bus.inj_cnt0_o    = cnt_q[0];
        bus.inj_cnt1_o    = cnt_q[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
            for (int l = 0; l < 2; l++) begin
                stv_q[l] <= '0;
                cnt_q[l] <= '0;
            end
        end else begin
            err_q <= err_q | (|(ack & ~full));
            for (int l = 0; l < 2; l++) begin
                if (full[l] && ack[l]) cnt_q[l] <= cnt_q[l] + 1'b1;
                if (full[l] && !ack[l]) begin
                    if (stv_q[l] != SMAX) stv_q[l] <= stv_q[l] + 1'b1;
                end else begin
                    stv_q[l] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hr_inject_ctrl.sv
// Scoreboard bench for hr_inject_ctrl: per-lane expected-flit queues
// plus a reference model of pointers, counters and flags.
module tb_hr_inject_ctrl;

    localparam int NREQ = 4;
    localparam int FW   = 144;
    localparam int CW   = 16;
    localparam int SMAX = 255;

    typedef logic [FW-1:0] flit_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hr_inject_ctrl_if #(.NREQ(NREQ), .FLIT_W(FW), .CNT_W(CW)) bus ();

    hr_inject_ctrl #(
        .NREQ       (NREQ),
        .FLIT_W     (FW),
        .STARVE_MAX (SMAX),
        .CNT_W      (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    flit_t           q0 [$];
    flit_t           q1 [$];
    flit_t           fl [NREQ];
    int              ptr  [2];
    int              win  [2];
    int              mstv [2];
    logic [CW-1:0]   mcnt [2];
    logic            merr;
    logic [NREQ-1:0] exp_rdy;

    function automatic int rr_pick(logic [NREQ-1:0] m, int p);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic flit_t exp_port(int l);
        if (l == 0) return (q0.size() != 0) ? q0[0] : '0;
        return (q1.size() != 0) ? q1[0] : '0;
    endfunction

    task automatic drive(input logic en, input logic [NREQ-1:0] v,
                         input logic [NREQ-1:0] ln, input logic a0,
                         input logic a1, input int tag);
        bus.cfg_en_i     = en;
        bus.req_valid_i  = v;
        bus.req_lane_i   = ln;
        bus.portl0_ack_i = a0;
        bus.portl1_ack_i = a1;
        for (int i = 0; i < NREQ; i++) begin
            fl[i] = {16'hF000 | 16'(i), 96'h0, 32'(tag)};
            bus.req_flit_i[i*FW +: FW] = fl[i];
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int l = 0; l < 2; l++) begin
            ptr[l]  = 0;
            win[l]  = -1;
            mstv[l] = 0;
            mcnt[l] = '0;
        end
        merr    = 1'b0;
        exp_rdy = '0;
    endtask

    task automatic model_eval();
        logic [NREQ-1:0] m;
        logic full, a, can;
        exp_rdy = '0;
        for (int l = 0; l < 2; l++) begin
            m    = bus.req_valid_i & ((l == 0) ? ~bus.req_lane_i : bus.req_lane_i);
            full = (l == 0) ? (q0.size() != 0) : (q1.size() != 0);
            a    = (l == 0) ? bus.portl0_ack_i : bus.portl1_ack_i;
            can  = rst && bus.cfg_en_i && (!full || a);
            win[l] = can ? rr_pick(m, ptr[l]) : -1;
            if (win[l] >= 0) exp_rdy[win[l]] = 1'b1;
        end
    endtask

    task automatic model_commit();
        logic full, a;
        if (!rst) return;
        for (int l = 0; l < 2; l++) begin
            full = (l == 0) ? (q0.size() != 0) : (q1.size() != 0);
            a    = (l == 0) ? bus.portl0_ack_i : bus.portl1_ack_i;
            mstv[l] = (full && !a) ? ((mstv[l] < SMAX) ? mstv[l] + 1 : SMAX) : 0;
            if (a && !full) merr = 1'b1;
            if (full && a) begin
                if (l == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
                mcnt[l] = mcnt[l] + 1'b1;
            end
            if (win[l] >= 0) begin
                if (l == 0) q0.push_back(fl[win[l]]);
                else q1.push_back(fl[win[l]]);
                ptr[l] = (win[l] + 1) % NREQ;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 1);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks += 7;
        if (bus.req_ready_o !== 4'b0) begin
            errors++; $display("FAIL rst_ready got %b want 0000", bus.req_ready_o);
        end
        if (bus.port0_local_o !== '0) begin
            errors++; $display("FAIL rst_port0 got %h want 0", bus.port0_local_o);
        end
        if (bus.port1_local_o !== '0) begin
            errors++; $display("FAIL rst_port1 got %h want 0", bus.port1_local_o);
        end
        if (bus.starve_o !== 2'b00) begin
            errors++; $display("FAIL rst_starve got %b want 00", bus.starve_o);
        end
        if (bus.ack_err_o !== 1'b0) begin
            errors++; $display("FAIL rst_ack_err got %b want 0", bus.ack_err_o);
        end
        if (bus.inj_cnt0_o !== '0) begin
            errors++; $display("FAIL rst_cnt0 got %0d want 0", bus.inj_cnt0_o);
        end
        if (bus.inj_cnt1_o !== '0) begin
            errors++; $display("FAIL rst_cnt1 got %0d want 0", bus.inj_cnt1_o);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_eval();
        checks++;
        if (bus.req_ready_o !== 4'b0001) begin
            errors++; $display("FAIL first_grant got %b want 0001", bus.req_ready_o);
        end
        drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 2);
        #1;
        model_eval();
        model_commit();
    endtask

    task automatic test_round_robin();
        int seq [5] = '{0, 1, 2, 3, 0};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            drive(1'b1, (c < 5) ? 4'hF : 4'h0, 4'h0, q0.size() != 0, 1'b0, 100 + c);
            #1;
            model_eval();
            checks += 2;
            if (bus.req_ready_o !== exp_rdy) begin
                errors++;
                $display("FAIL rr_ready c%0d got %b want %b", c, bus.req_ready_o, exp_rdy);
            end
            if (bus.port0_local_o !== exp_port(0)) begin
                errors++;
                $display("FAIL rr_port0 c%0d got %h want %h", c, bus.port0_local_o, exp_port(0));
            end
            if (c < 5) begin
                checks++;
                if (bus.req_ready_o !== NREQ'(1 << seq[c])) begin
                    errors++;
                    $display("FAIL rr_seq c%0d got %b want req %0d", c, bus.req_ready_o, seq[c]);
                end
            end
            model_commit();
        end
        checks++;
        if (bus.inj_cnt0_o !== mcnt[0]) begin
            errors++; $display("FAIL rr_cnt0 got %0d want %0d", bus.inj_cnt0_o, mcnt[0]);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        drive(1'b1, 4'b0001, 4'h0, 1'b0, 1'b0, 32'h1855);
        #1;
        model_eval();
        checks++;
        if (bus.req_ready_o !== exp_rdy) begin
            errors++; $display("FAIL single_ready got %b want %b", bus.req_ready_o, exp_rdy);
        end
        model_commit();
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            drive(1'b1, 4'h0, 4'h0, c == 11, 1'b0, 0);
            #1;
            model_eval();
            checks++;
            if (bus.port0_local_o !== exp_port(0)) begin
                errors++;
                $display("FAIL single_port0 c%0d got %h want %h", c, bus.port0_local_o, exp_port(0));
            end
            model_commit();
        end
        checks++;
        if (bus.inj_cnt0_o !== mcnt[0]) begin
            errors++; $display("FAIL single_cnt0 got %0d want %0d", bus.inj_cnt0_o, mcnt[0]);
        end
    endtask

    task automatic test_dual_lane();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, (c == 0) ? 4'b0011 : 4'b0000, 4'b0010, c == 1, c == 1, 7 + c);
            #1;
            model_eval();
            checks += 3;
            if (bus.req_ready_o !== exp_rdy) begin
                errors++;
                $display("FAIL dual_ready c%0d got %b want %b", c, bus.req_ready_o, exp_rdy);
            end
            if (bus.port0_local_o !== exp_port(0)) begin
                errors++;
                $display("FAIL dual_port0 c%0d got %h want %h", c, bus.port0_local_o, exp_port(0));
            end
            if (bus.port1_local_o !== exp_port(1)) begin
                errors++;
                $display("FAIL dual_port1 c%0d got %h want %h", c, bus.port1_local_o, exp_port(1));
            end
            model_commit();
        end
        checks++;
        if (bus.inj_cnt1_o !== mcnt[1]) begin
            errors++; $display("FAIL dual_cnt1 got %0d want %0d", bus.inj_cnt1_o, mcnt[1]);
        end
    endtask

    task automatic test_starve();
        @(negedge clk);
        drive(1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 9);
        #1;
        model_eval();
        checks++;
        if (bus.req_ready_o !== exp_rdy) begin
            errors++; $display("FAIL starve_ready got %b want %b", bus.req_ready_o, exp_rdy);
        end
        model_commit();
        for (int k = 0; k <= 256; k++) begin
            @(negedge clk);
            drive(1'b1, 4'h0, 4'h0, 1'b0, k == 255, 0);
            #1;
            model_eval();
            if (k >= 254) begin
                checks += 2;
                if (bus.starve_o !== {mstv[1] == SMAX, mstv[0] == SMAX}) begin
                    errors++;
                    $display("FAIL starve_flag k%0d got %b want lane1 cnt %0d", k, bus.starve_o, mstv[1]);
                end
                if (bus.port1_local_o !== exp_port(1)) begin
                    errors++;
                    $display("FAIL starve_port1 k%0d got %h want %h", k, bus.port1_local_o, exp_port(1));
                end
            end
            model_commit();
        end
    endtask

    task automatic test_cfg_en();
        @(negedge clk);
        drive(1'b1, 4'b0010, 4'h0, 1'b0, 1'b0, 11);
        #1;
        model_eval();
        model_commit();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b0, 4'b0010, 4'h0, c == 1, 1'b0, 12 + c);
            #1;
            model_eval();
            checks += 2;
            if (bus.req_ready_o !== exp_rdy) begin
                errors++;
                $display("FAIL cfg_ready c%0d got %b want %b", c, bus.req_ready_o, exp_rdy);
            end
            if (bus.port0_local_o !== exp_port(0)) begin
                errors++;
                $display("FAIL cfg_port0 c%0d got %h want %h", c, bus.port0_local_o, exp_port(0));
            end
            model_commit();
        end
    endtask

    task automatic test_ack_err();
        checks++;
        if (bus.ack_err_o !== 1'b0) begin
            errors++; $display("FAIL err_pre got %b want 0", bus.ack_err_o);
        end
        @(negedge clk);
        drive(1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 0);
        #1;
        model_eval();
        model_commit();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 0);
            #1;
            model_eval();
            checks += 2;
            if (bus.ack_err_o !== merr) begin
                errors++; $display("FAIL err_sticky c%0d got %b want %b", c, bus.ack_err_o, merr);
            end
            if (bus.inj_cnt0_o !== mcnt[0]) begin
                errors++; $display("FAIL err_cnt0 c%0d got %0d want %0d", c, bus.inj_cnt0_o, mcnt[0]);
            end
            model_commit();
        end
    endtask

    task automatic test_wrap();
        int n, pushed, budget;
        n      = 65536 - int'(mcnt[0]);
        pushed = 0;
        budget = n + 8;
        while ((pushed < n || q0.size() != 0) && budget > 0) begin
            @(negedge clk);
            drive(1'b1, (pushed < n) ? 4'b1000 : 4'b0000, 4'h0, q0.size() != 0, 1'b0, budget);
            #1;
            model_eval();
            checks++;
            if (bus.port0_local_o !== exp_port(0)) begin
                errors++;
                $display("FAIL wrap_port0 got %h want %h", bus.port0_local_o, exp_port(0));
            end
            if (win[0] >= 0) pushed++;
            model_commit();
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++; $display("FAIL wrap_budget got %0d flits want %0d", pushed, n);
        end
        @(negedge clk);
        drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 0);
        #1;
        checks += 2;
        if (bus.inj_cnt0_o !== mcnt[0]) begin
            errors++; $display("FAIL wrap_cnt0 got %0d want %0d", bus.inj_cnt0_o, mcnt[0]);
        end
        if (bus.inj_cnt0_o !== 16'h0000) begin
            errors++; $display("FAIL wrap_zero got %0d want 0", bus.inj_cnt0_o);
        end
        model_eval();
        model_commit();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(1'b1, 4'b0001, 4'h0, 1'b0, 1'b0, 21);
        #1;
        model_eval();
        model_commit();
        @(negedge clk);
        drive(1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 22);
        #1;
        checks++;
        if (bus.port0_local_o !== exp_port(0)) begin
            errors++; $display("FAIL mid_held got %h want %h", bus.port0_local_o, exp_port(0));
        end
        rst = 1'b0;
        model_reset();
        #1;
        checks += 4;
        if (bus.port0_local_o !== '0) begin
            errors++; $display("FAIL mid_port0 got %h want 0", bus.port0_local_o);
        end
        if (bus.req_ready_o !== 4'b0) begin
            errors++; $display("FAIL mid_ready got %b want 0000", bus.req_ready_o);
        end
        if (bus.inj_cnt0_o !== mcnt[0]) begin
            errors++; $display("FAIL mid_cnt0 got %0d want %0d", bus.inj_cnt0_o, mcnt[0]);
        end
        if (bus.ack_err_o !== 1'b0) begin
            errors++; $display("FAIL mid_err got %b want 0", bus.ack_err_o);
        end
        @(negedge clk);
        drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.port0_local_o !== '0) begin
            errors++; $display("FAIL mid_discard got %h want 0", bus.port0_local_o);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_dual_lane();
        test_starve();
        test_cfg_en();
        test_ack_err();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
